// File: rtl/memory_game_ctrl.sv
// Concentration-style memory game controller for a 4x4 card grid.
// Tracks cursor, face-up/matched cards, pair and attempt counts; all outputs registered.
module memory_game_ctrl #(
    parameter int unsigned SHOW_TICKS = 60,
    parameter logic [63:0] LAYOUT     = 64'h7654_3210_0123_4567
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_sel,
    output logic [3:0]  cursor,
    output logic [15:0] face_up,
    output logic [15:0] matched,
    output logic [3:0]  pairs_found,
    output logic [7:0]  attempts,
    output logic        game_done,
    output logic        busy
);

    localparam int unsigned EFF_TICKS = (SHOW_TICKS == 0) ? 1 : SHOW_TICKS;
    localparam int unsigned CNT_W     = ($clog2(SHOW_TICKS + 1) < 1) ? 1 : $clog2(SHOW_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EFF_TICKS - 1);

    typedef enum logic [2:0] {PICK1, PICK2, CHECK, SHOW, DONE} state_t;

    state_t           state_q, state_d;
    logic [3:0]       first_q, first_d, second_q, second_d;
    logic [3:0]       cursor_d;
    logic [15:0]      face_up_d, matched_d;
    logic [3:0]       pairs_d;
    logic [7:0]       attempts_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_d, done_d;
    logic [1:0]       row_d, col_d;
    logic [5:0]       first_base, second_base;
    logic             sel_valid, pair_equal, show_expire;

    assign first_base  = {first_q, 2'b00};
    assign second_base = {second_q, 2'b00};
    assign pair_equal  = (LAYOUT[first_base +: 4] == LAYOUT[second_base +: 4]);
    assign sel_valid   = btn_sel && !face_up[cursor] && (state_q == PICK1 || state_q == PICK2);
    assign show_expire = tick && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= PICK1;
            cursor      <= '0;
            face_up     <= '0;
            matched     <= '0;
            pairs_found <= '0;
            attempts    <= '0;
            game_done   <= 1'b0;
            busy        <= 1'b0;
            cnt_q       <= '0;
            first_q     <= '0;
            second_q    <= '0;
        end else begin
            state_q     <= state_d;
            cursor      <= cursor_d;
            face_up     <= face_up_d;
            matched     <= matched_d;
            pairs_found <= pairs_d;
            attempts    <= attempts_d;
            game_done   <= done_d;
            busy        <= busy_d;
            cnt_q       <= cnt_d;
            first_q     <= first_d;
            second_q    <= second_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PICK1:   if (sel_valid) state_d = PICK2;
            PICK2:   if (sel_valid) state_d = CHECK;
            CHECK: begin
                if (!pair_equal)             state_d = SHOW;
                else if (pairs_found == 4'd7) state_d = DONE;
                else                         state_d = PICK1;
            end
            SHOW:    if (show_expire) state_d = PICK1;
            DONE:    state_d = DONE;
            default: state_d = PICK1;
        endcase
    end

    always_comb begin
        face_up_d  = face_up;
        matched_d  = matched;
        pairs_d    = pairs_found;
        attempts_d = attempts;
        cnt_d      = cnt_q;
        first_d    = first_q;
        second_d   = second_q;

        // Single move per cycle, priority left > right > up > down; 2-bit wrap.
        row_d = cursor[3:2];
        col_d = cursor[1:0];
        if (btn_left)       col_d = col_d - 2'd1;
        else if (btn_right) col_d = col_d + 2'd1;
        else if (btn_up)    row_d = row_d - 2'd1;
        else if (btn_down)  row_d = row_d + 2'd1;
        cursor_d = (state_q == DONE) ? cursor : {row_d, col_d};

        case (state_q)
            PICK1: begin
                if (sel_valid) begin
                    face_up_d[cursor] = 1'b1;
                    first_d           = cursor;
                end
            end
            PICK2: begin
                if (sel_valid) begin
                    face_up_d[cursor] = 1'b1;
                    second_d          = cursor;
                    if (attempts != 8'hFF) attempts_d = attempts + 8'd1;
                end
            end
            CHECK: begin
                if (pair_equal) begin
                    matched_d[first_q]  = 1'b1;
                    matched_d[second_q] = 1'b1;
                    pairs_d             = pairs_found + 4'd1;
                end else begin
                    cnt_d = '0;
                end
            end
            SHOW: begin
                if (tick) cnt_d = cnt_q + 1'b1;
                if (show_expire) begin
                    face_up_d[first_q]  = 1'b0;
                    face_up_d[second_q] = 1'b0;
                end
            end
            default: ;
        endcase

        busy_d = (state_d == CHECK) || (state_d == SHOW);
        done_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Self-checking bench for memory_game_ctrl: directed scenarios plus random play
// compared cycle by cycle against a turn-based reference model.
module tb_memory_game_ctrl;

    localparam int unsigned SHOW_T   = 60;
    localparam logic [63:0] LAYOUT_C = 64'h7654_3210_0123_4567;

    logic        clk = 1'b0;
    logic        reset = 1'b0, tick = 1'b0;
    logic        btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_down = 1'b0, btn_sel = 1'b0;
    logic [3:0]  cursor;
    logic [15:0] face_up, matched;
    logic [3:0]  pairs_found;
    logic [7:0]  attempts;
    logic        game_done, busy;

    memory_game_ctrl #(.SHOW_TICKS(SHOW_T), .LAYOUT(LAYOUT_C)) dut (
        .clk(clk), .reset(reset), .tick(tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
        .btn_down(btn_down), .btn_sel(btn_sel),
        .cursor(cursor), .face_up(face_up), .matched(matched),
        .pairs_found(pairs_found), .attempts(attempts),
        .game_done(game_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: a turn of the game, not a state machine.
    int          m_row, m_col, m_a, m_b, m_ticks, m_pairs, m_att;
    logic [15:0] m_up, m_match;
    bit          m_done, m_check, m_hiding, m_have_first;

    function automatic int card_id(input int p);
        logic [63:0] l;
        l = LAYOUT_C >> (4 * p);
        return int'(l[3:0]);
    endfunction

    function automatic logic [49:0] exp_vec();
        return {4'(m_row * 4 + m_col), m_up, m_match, 4'(m_pairs), 8'(m_att),
                logic'(m_done), logic'(m_check || m_hiding)};
    endfunction

    function automatic logic [49:0] act_vec();
        return {cursor, face_up, matched, pairs_found, attempts, game_done, busy};
    endfunction

    task automatic model_step(input bit r, t, l, rt, u, d, s);
        int pos;
        bit was_done;
        int limit;
        limit = (SHOW_T == 0) ? 1 : SHOW_T;
        if (r) begin
            m_row = 0; m_col = 0; m_a = 0; m_b = 0; m_ticks = 0; m_pairs = 0; m_att = 0;
            m_up = '0; m_match = '0; m_done = 0; m_check = 0; m_hiding = 0; m_have_first = 0;
            return;
        end
        was_done = m_done;
        pos = m_row * 4 + m_col;
        if (!m_done) begin
            if (m_check) begin
                m_check = 0;
                if (card_id(m_a) == card_id(m_b)) begin
                    m_match[m_a] = 1'b1;
                    m_match[m_b] = 1'b1;
                    m_pairs++;
                    if (m_pairs == 8) m_done = 1;
                end else begin
                    m_hiding = 1;
                    m_ticks  = 0;
                end
            end else if (m_hiding) begin
                if (t) begin
                    m_ticks++;
                    if (m_ticks >= limit) begin
                        m_up[m_a] = 1'b0;
                        m_up[m_b] = 1'b0;
                        m_hiding  = 0;
                    end
                end
            end else if (s && !m_up[pos]) begin
                m_up[pos] = 1'b1;
                if (!m_have_first) begin
                    m_a = pos;
                    m_have_first = 1;
                end else begin
                    m_b = pos;
                    m_have_first = 0;
                    if (m_att < 255) m_att++;
                    m_check = 1;
                end
            end
        end
        if (!was_done) begin
            if (l)       m_col = (m_col + 3) % 4;
            else if (rt) m_col = (m_col + 1) % 4;
            else if (u)  m_row = (m_row + 3) % 4;
            else if (d)  m_row = (m_row + 1) % 4;
        end
    endtask

    task automatic drive(input bit r, t, l, rt, u, d, s);
        reset = r; tick = t; btn_left = l; btn_right = rt; btn_up = u; btn_down = d; btn_sel = s;
        @(posedge clk);
        model_step(r, t, l, rt, u, d, s);
        #1;
        reset = 0; tick = 0; btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0; btn_sel = 0;
    endtask

    task automatic test_reset();
        drive(1, 1, 1, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0, 0);
        total++;
        if (act_vec() !== 50'b0) begin
            bad++; $display("FAIL reset_state: got %h want %h", act_vec(), 50'b0);
        end
    endtask

    task automatic test_match();
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);              // select pos 0
        drive(0, 0, 1, 0, 0, 0, 0);              // left -> col 3
        drive(0, 0, 0, 0, 1, 0, 0);              // up   -> row 3, pos 15
        total++;
        if (cursor !== 4'd15) begin bad++; $display("FAIL match_cursor: got %0d want 15", cursor); end
        drive(0, 0, 0, 0, 0, 0, 1);              // select pos 15
        total++;
        if (act_vec() !== exp_vec()) begin
            bad++; $display("FAIL match_second_sel: got %h want %h", act_vec(), exp_vec());
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        total++;
        if (matched !== 16'h8001 || pairs_found !== 4'd1 || busy !== 1'b0 || attempts !== 8'd1) begin
            bad++; $display("FAIL match_result: got matched=%h pairs=%0d busy=%b att=%0d want 8001 1 0 1",
                            matched, pairs_found, busy, attempts);
        end
        total++;
        if (act_vec() !== exp_vec()) begin
            bad++; $display("FAIL match_model: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_mismatch();
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        total++;
        if (busy !== 1'b1 || face_up !== 16'h0003 || attempts !== 8'd1) begin
            bad++; $display("FAIL mismatch_check: got busy=%b face=%h att=%0d want 1 0003 1", busy, face_up, attempts);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 1; i <= 60; i++) begin
            drive(0, 1, 0, 0, 0, 0, 0);
            total++;
            if (i < 60) begin
                if (face_up !== 16'h0003 || busy !== 1'b1) begin
                    bad++; $display("FAIL mismatch_hold tick %0d: got face=%h busy=%b want 0003 1", i, face_up, busy);
                end
            end else begin
                if (face_up !== 16'h0000 || busy !== 1'b0 || attempts !== 8'd1) begin
                    bad++; $display("FAIL mismatch_release: got face=%h busy=%b att=%0d want 0000 0 1", face_up, busy, attempts);
                end
            end
            drive(0, 0, 0, 0, 0, 0, 0);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL mismatch_model tick %0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_ignored();
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1);              // same position again
        total++;
        if (face_up !== 16'h0001 || attempts !== 8'd0 || busy !== 1'b0 || act_vec() !== exp_vec()) begin
            bad++; $display("FAIL ignored_same_pos: got %h want %h", act_vec(), exp_vec());
        end
        drive(0, 0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0);              // now in SHOW
        drive(0, 0, 0, 0, 0, 1, 0);              // cursor to pos 5
        drive(0, 0, 0, 0, 0, 0, 1);              // select during SHOW
        total++;
        if (face_up !== 16'h0003 || attempts !== 8'd1 || busy !== 1'b1 || cursor !== 4'd5) begin
            bad++; $display("FAIL ignored_show_sel: got face=%h att=%0d busy=%b cur=%0d want 0003 1 1 5",
                            face_up, attempts, busy, cursor);
        end
        for (int i = 0; i < SHOW_T; i++) drive(0, 1, 0, 0, 0, 0, 0);
        total++;
        if (act_vec() !== exp_vec() || face_up !== 16'h0) begin
            bad++; $display("FAIL ignored_after_show: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_wrap();
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0, 0);
        total++;
        if (cursor !== 4'd3) begin bad++; $display("FAIL wrap_left: got %0d want 3", cursor); end
        drive(0, 0, 0, 0, 1, 0, 0);
        total++;
        if (cursor !== 4'd15) begin bad++; $display("FAIL wrap_up: got %0d want 15", cursor); end
        drive(0, 0, 1, 0, 0, 1, 0);
        total++;
        if (cursor !== 4'd14) begin bad++; $display("FAIL wrap_priority: got %0d want 14", cursor); end
        drive(0, 0, 0, 1, 1, 1, 0);              // right beats up/down: 14 -> 15
        total++;
        if (cursor !== 4'd15) begin bad++; $display("FAIL wrap_right_prio: got %0d want 15", cursor); end
    endtask

    task automatic test_full_game();
        int tgt;
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int j = 0; j < 16; j++) begin
            tgt = (j % 2 == 0) ? j / 2 : 15 - j / 2;
            for (int k = 0; k < 8 && (m_row * 4 + m_col) != tgt; k++) begin
                if (m_col != tgt % 4) drive(0, 0, 0, 1, 0, 0, 0);
                else                  drive(0, 0, 0, 0, 0, 1, 0);
            end
            drive(0, 0, 0, 0, 0, 0, 1);
            if (j % 2 == 1) drive(0, 0, 0, 0, 0, 0, 0);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL full_game step %0d: got %h want %h", j, act_vec(), exp_vec());
            end
        end
        total++;
        if (game_done !== 1'b1 || pairs_found !== 4'd8 || matched !== 16'hFFFF || face_up !== 16'hFFFF
            || attempts !== 8'd8 || busy !== 1'b0) begin
            bad++; $display("FAIL full_game_done: got done=%b pairs=%0d matched=%h face=%h att=%0d busy=%b",
                            game_done, pairs_found, matched, face_up, attempts, busy);
        end
        for (int i = 0; i < 20; i++) begin
            drive(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL done_hold %0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_reset_mid_show();
        drive(1, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 1);              // pos 0 and pos 4 differ
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 0, 0, 0, 0, 0);
        total++;
        if (busy !== 1'b1 || face_up !== 16'h0011) begin
            bad++; $display("FAIL pre_reset_show: got busy=%b face=%h want 1 0011", busy, face_up);
        end
        drive(1, 1, 1, 0, 0, 0, 1);
        total++;
        if (act_vec() !== 50'b0) begin
            bad++; $display("FAIL reset_mid_show: got %h want %h", act_vec(), 50'b0);
        end
        drive(0, 1, 0, 0, 0, 0, 0);
        total++;
        if (act_vec() !== exp_vec()) begin
            bad++; $display("FAIL after_reset: got %h want %h", act_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        bit r, t, l, rt, u, d, s;
        drive(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 599) == 0);
            t  = ($urandom_range(0, 1) == 1);
            l  = ($urandom_range(0, 4) == 0);
            rt = ($urandom_range(0, 4) == 0);
            u  = ($urandom_range(0, 4) == 0);
            d  = ($urandom_range(0, 4) == 0);
            s  = ($urandom_range(0, 2) == 0);
            drive(r, t, l, rt, u, d, s);
            total++;
            if (act_vec() !== exp_vec()) begin
                bad++; $display("FAIL random cycle %0d: got %h want %h", i, act_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_match();
        test_mismatch();
        test_ignored();
        test_wrap();
        test_full_game();
        test_reset_mid_show();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
